// File: rtl/hdc_pkg.sv
// Shared definitions for the hypervector bundling encoder: default geometry,
// FSM state encoding and the tie-break LFSR constants.
package hdc_pkg;

    localparam int DIM_DEF   = 1024;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting towards the MSB
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/hv_bit_acc.sv
// One dimension of the bundler: a ones-counter plus the threshold / majority
// comparator evaluated on the post-beat count, with a separate tie flag.
module hv_bit_acc
    import hdc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             maj_mode,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] thre,
    output logic             hit,
    output logic             tie
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] acc_r;
    logic [CNT_W-1:0] acc_nxt_s;
    logic [CNT_W:0]   lhs_s;
    logic [CNT_W:0]   rhs_s;

    // Next count includes the current beat so the result can be registered on the last beat
    always_comb begin
        acc_nxt_s = acc_r;
        if (inc) begin
            acc_nxt_s = acc_r + CNT_ONE;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Majority compares 2*acc against cnt; external compares acc against thre, both at CNT_W+1 bits
    always_comb begin
        lhs_s = {(CNT_W+1){1'b0}};
        rhs_s = {(CNT_W+1){1'b0}};
        if (maj_mode) begin
            lhs_s = {acc_nxt_s, 1'b0};
            rhs_s = {1'b0, cnt};
        end else begin
            lhs_s = {1'b0, acc_nxt_s};
            rhs_s = {1'b0, thre};
        end
    end

    // Comparator outputs
    always_comb begin
        hit = (lhs_s > rhs_s);
        tie = maj_mode & (lhs_s == rhs_s);
    end

    // Ones counter; clear has priority over a coincident beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            acc_r <= {CNT_W{1'b0}};
        end else begin
            acc_r <= acc_nxt_s;
        end
    end

endmodule

// File: rtl/hv_bundler.sv
// Streaming hypervector bundler with valid/ready handshakes.
// Optional build macro HV_BUNDLER_TIEBREAK_EN: LFSR tie-break for majority ties.
module hv_bundler
    import hdc_pkg::*;
#(
    parameter int DIM   = DIM_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] thre,
    input  logic             maj_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIM-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIM-1:0]   enc,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] beat_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] thre_r;
    logic             maj_r;
    logic [DIM-1:0]   enc_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             busy_r;

    logic             beat_s;
    logic             last_s;
    logic             clr_acc_s;
    logic [DIM-1:0]   hit_s;
    logic [DIM-1:0]   tie_s;
    logic [DIM-1:0]   tb_bit_s;
    logic [DIM-1:0]   enc_nxt_s;

    // Beat qualification; in_ready is only ever high in ACC
    always_comb begin
        beat_s    = in_valid & in_ready_r;
        last_s    = beat_s & (beat_r == (cnt_r - CNT_ONE));
        clr_acc_s = clr | ((state_r == ST_IDLE) & start);
        enc_nxt_s = hit_s | (tie_s & tb_bit_s);
    end

    for (genvar d = 0; d < DIM; d++) begin : g_dim
        hv_bit_acc #(.CNT_W(CNT_W)) u_acc (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr_acc_s),
            .inc      (beat_s & in_data[d]),
            .maj_mode (maj_r),
            .cnt      (cnt_r),
            .thre     (thre_r),
            .hit      (hit_s[d]),
            .tie      (tie_s[d])
        );
    end

`ifdef HV_BUNDLER_TIEBREAK_EN
    logic [15:0] lfsr_r;

    // Tie-break sequence advances once per completed output handshake; clr leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (out_valid_r && out_ready) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    for (genvar d = 0; d < DIM; d++) begin : g_tb
        assign tb_bit_s[d] = lfsr_r[d % 16];
    end
`else
    assign tb_bit_s = {DIM{1'b0}};
`endif

    // Frame control FSM with registered handshake outputs; clr aborts to IDLE but keeps enc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            beat_r      <= {CNT_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            thre_r      <= {CNT_W{1'b0}};
            maj_r       <= 1'b0;
            enc_r       <= {DIM{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else if (clr) begin
            state_r     <= ST_IDLE;
            beat_r      <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt_r  <= cnt;
                        thre_r <= thre;
                        maj_r  <= maj_mode;
                        beat_r <= {CNT_W{1'b0}};
                        busy_r <= 1'b1;
                        if (cnt != {CNT_W{1'b0}}) begin
                            state_r    <= ST_ACC;
                            in_ready_r <= 1'b1;
                        end else begin
                            state_r     <= ST_HOLD;
                            enc_r       <= {DIM{1'b0}};
                            out_valid_r <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_ACC: begin
                    if (beat_s) begin
                        beat_r <= beat_r + CNT_ONE;
                        if (last_s) begin
                            enc_r       <= enc_nxt_s;
                            state_r     <= ST_HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_ACC;
                        end
                    end else begin
                        state_r <= ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    beat_r      <= {CNT_W{1'b0}};
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign enc       = enc_r;
    assign busy      = busy_r;

endmodule
